// File: rtl/spi_alu_slave.sv
// SPI-framed ALU slave: 3-bit opcode + DW-bit data per frame, A/B regs.
// Ports: clk, n_rst, sclk/ss/mosi in; result, result_vld, carry,
// frame_err out; miso readback only when SPI_MISO_EN is defined.
module spi_alu_slave #(
  parameter  int DW  = 4,
  localparam int OPW = 3
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          sclk,
  input  logic          ss,
  input  logic          mosi,
  output logic [DW-1:0] result,
  output logic          result_vld,
  output logic          carry,
  output logic          frame_err
`ifdef SPI_MISO_EN
  ,
  output logic          miso
`endif
);

  localparam int FLEN = OPW + DW;
  localparam int CW   = $clog2(FLEN + 1);

  typedef enum logic [2:0] {
    IDLE, OPC, DATA, EXEC, WAIT
  } state_t;

  state_t state, state_n;

  logic sclk_s1, sclk_s2, sclk_d;
  logic ss_s1, ss_s2, ss_d;
  logic mosi_s1, mosi_s2;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
      ss_d    <= ss_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  logic sclk_rise, ss_fall, ss_rise, sample;

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign ss_fall   = ~ss_s2 & ss_d;
  assign ss_rise   = ss_s2 & ~ss_d;
  // ss_d (not ss_s2) gates sampling so a last edge that lands
  // together with ss rising still counts as part of the frame.
  assign sample    = sclk_rise & ~ss_d;

  logic [CW-1:0]   cnt, cnt_n;
  logic [FLEN-1:0] sh;
  logic            shift, commit, abort;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift   = 1'b0;
    commit  = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ss_fall) begin
          state_n = OPC;
          cnt_n   = '0;
        end
      end
      OPC: begin
        if (ss_rise) begin
          abort   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (sample) begin
          shift = 1'b1;
          cnt_n = cnt + CW'(1);
          if (cnt == CW'(OPW - 1))
            state_n = DATA;
        end
      end
      DATA: begin
        if (sample && cnt == CW'(FLEN - 1)) begin
          shift   = 1'b1;
          cnt_n   = cnt + CW'(1);
          state_n = EXEC;
        end else if (ss_rise) begin
          abort   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (sample) begin
          shift = 1'b1;
          cnt_n = cnt + CW'(1);
        end
      end
      EXEC: begin
        commit  = 1'b1;
        state_n = ss_s2 ? IDLE : WAIT;
        cnt_n   = '0;
      end
      WAIT: begin
        if (ss_rise)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  logic [OPW-1:0] op;
  logic [DW-1:0]  data;
  logic [DW-1:0]  a, b;
  logic [DW:0]    sum;

  assign op   = sh[FLEN-1 -: OPW];
  assign data = sh[DW-1:0];
  assign sum  = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sh         <= '0;
      a          <= '0;
      b          <= '0;
      result     <= '0;
      carry      <= 1'b0;
      result_vld <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      result_vld <= 1'b0;
      frame_err  <= abort;
      if (shift)
        sh <= {sh[FLEN-2:0], mosi_s2};
      if (commit) begin
        result_vld <= (op != 3'd0);
        unique case (op)
          3'd0: ;
          3'd1: begin
            a      <= data;
            result <= data;
          end
          3'd2: begin
            b      <= data;
            result <= data;
          end
          3'd3: begin
            result <= sum[DW-1:0];
            carry  <= sum[DW];
          end
          3'd4: begin
            result <= a - b;
            carry  <= (a < b);
          end
          3'd5: result <= a & b;
          3'd6: result <= a | b;
          3'd7: result <= a ^ b;
        endcase
      end
    end
  end

`ifdef SPI_MISO_EN
  logic            sclk_fall, in_frame;
  logic [FLEN-1:0] mreg;

  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign in_frame  = (state == OPC) || (state == DATA);

  // Leading OPW zeros line up the result with the data field.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      mreg <= '0;
    else if (state == IDLE && ss_fall)
      mreg <= {{OPW{1'b0}}, result};
    else if (in_frame && sclk_fall)
      mreg <= {mreg[FLEN-2:0], 1'b0};
  end

  assign miso = in_frame ? mreg[FLEN-1] : 1'b0;
`endif

endmodule

// File: doc/spi_alu_slave.md
SPI_ALU_SLAVE -- requirements
Module: spi_alu_slave

Interface
REQ-001 Parameter DW, default 4: data/operand/result width, legal range 4..16.
REQ-002 Parameter OPW, fixed 3: opcode field width (not overridable).
REQ-003 Port clk  input  1: system clock; the one and only clock, all logic on its rising edge.
REQ-004 Port n_rst  input  1: asynchronous, active-low reset.
REQ-005 Port sclk  input  1: SPI serial clock, asynchronous to clk, idle low.
REQ-006 Port ss  input  1: SPI slave select, active low, idle high.
REQ-007 Port mosi  input  1: SPI serial data in, MSB first.
REQ-008 Port result  output  DW: last committed result.
REQ-009 Port result_vld  output  1: one-clk pulse when result commits.
REQ-010 Port carry  output  1: carry/borrow of last ADD/SUB.
REQ-011 Port frame_err  output  1: one-clk pulse on aborted frame.
REQ-012 Port miso  output  1: serial readback; present only with SPI_MISO_EN.

Function
REQ-013 sclk, ss and mosi SHALL each pass a 2-FF synchronizer; sclk edges are detected on the synchronized copies; a legal sclk high or low phase is >= 4 clk.
REQ-014 mosi SHALL be sampled on each detected sclk rising edge while synchronized ss is low.
REQ-015 Frame: OPW opcode bits, then DW data bits, MSB first; FLEN = OPW+DW bits.
REQ-016 FSM states: IDLE, OPC, DATA, EXEC, WAIT.
REQ-017 IDLE->OPC on ss falling; bit counter cleared to 0.
REQ-018 OPC->DATA after the OPW-th sampled bit; DATA->EXEC after the FLEN-th sampled bit.
REQ-019 EXEC lasts 1 clk and commits; then ->WAIT, or ->IDLE if ss is already high.
REQ-020 WAIT: further sclk edges ignored; ->IDLE on ss rising.
REQ-021 ss rising in OPC or DATA SHALL pulse frame_err for 1 clk, ->IDLE, and leave A, B, result and carry unchanged.
REQ-022 The FLEN-th edge and ss rising in the same clk SHALL count as a complete frame: no error.
REQ-023 Opcodes: 000 NOP; 001 LDA (A=data, result=data); 010 LDB (B=data, result=data); 011 ADD (result=A+B); 100 SUB (result=A-B); 101 AND; 110 OR; 111 XOR.
REQ-024 ALU opcodes SHALL ignore the data field.
REQ-025 ADD/SUB: results are modulo 2^DW; carry = bit DW of the DW+1-bit sum, or the borrow (A<B) for SUB.
REQ-026 Other opcodes SHALL leave carry unchanged.
REQ-027 NOP SHALL change no register and raise no result_vld.
REQ-028 Commit latency: result, carry and result_vld update in the EXEC clk, i.e. 1 clk after the clk in which the FLEN-th edge is detected.

Reset
REQ-029 On n_rst low, asynchronously: state=IDLE, counter=0, A=B=0, result=0, carry=0, result_vld=0, frame_err=0, miso=0, synchronizers cleared to ss=1, sclk=0, mosi=0.
REQ-030 Reset mid-frame SHALL discard the frame; after release, the FSM waits in IDLE for a fresh ss falling edge.

Configuration
REQ-031 Macro SPI_MISO_EN defined: miso port exists and shifts out the previously committed result, MSB first.
REQ-032 With SPI_MISO_EN, the shift register loads on ss falling, updates on each sclk falling edge in OPC/DATA, and drives 0 for the first OPW bits, in WAIT and while ss is high.
REQ-033 SPI_MISO_EN undefined: no miso port and no readback logic.

Verification (DW=4)
REQ-034 Reset, then frame 001_0101 -> result=0x5, one result_vld pulse, carry=0.
REQ-035 LDA 0x3, LDB 0x5, then ADD -> result=0x8, carry=0.
REQ-036 LDA 0xF, LDB 0x1, then ADD -> result=0x0, carry=1; then SUB -> result=0xE, carry=0.
REQ-037 LDA 0x3, LDB 0x5, then SUB -> result=0xE, carry=1; then XOR -> result=0x6, carry stays 1.
REQ-038 ss raised after 4 of 7 bits -> frame_err pulse, result and no result_vld change; the next full LDA 0x9 -> result=0x9.
REQ-039 n_rst asserted after 5 bits -> all outputs 0; with SPI_MISO_EN, after LDA 0xA the next frame's miso reads 000_1010.
